eth_tx_arb: RTL and testbench
=============================

ETH_TX_ARB -- requirements
Module: eth_tx_arb

Interface
REQ-001 The block SHALL have one clock and one reset: gmii_tx_clk, and gmii_rstn, which is asynchronous and active-low.
REQ-002 Parameter IFG_CYCLES, 12, idle cycles enforced between frames.
REQ-003 Parameter TIMEOUT_CYCLES, 4096, maximum cycles from tx_start to tx_done.
REQ-004 gmii_tx_clk  in  1  clock, 125 MHz.
REQ-005 gmii_rstn  in  1  asynchronous active-low reset.
REQ-006 arp_req  in  1  one-cycle pulse requesting an ARP reply (from eth_rx arp_data_valid).
REQ-007 arp_mac  in  48  requester MAC, sampled when arp_req=1.
REQ-008 udp_req  in  1  level request; held until udp_ack.
REQ-009 udp_len  in  11  UDP payload length in bytes; valid range 1..1472.
REQ-010 udp_mac  in  48  destination MAC for UDP frames, sampled at grant.
REQ-011 tx_done  in  1  one-cycle pulse from the frame builder when its last FCS byte is sent.
REQ-012 udp_ack  out  1  one-cycle pulse, UDP request consumed.
REQ-013 udp_len_err  out  1  one-cycle pulse, UDP request rejected for bad length.
REQ-014 arp_pending  out  1  ARP reply is latched and not yet granted.
REQ-015 tx_start  out  1  one-cycle pulse starting the frame builder.
REQ-016 tx_sel  out  1  frame type: 0 = UDP, 1 = ARP.
REQ-017 tx_len  out  11  payload length; 28 for ARP.
REQ-018 tx_dst_mac  out  48  destination MAC.
REQ-019 tx_active  out  1  high from tx_start to the end of the IFG.
REQ-020 tx_timeout  out  1  one-cycle pulse when a frame is abandoned.

Function
REQ-021 The FSM SHALL have states IDLE, GRANT, WAIT_DONE and IFG.
REQ-022 IDLE → GRANT on the cycle after any valid request is pending; IDLE with nothing pending → stays in IDLE.
REQ-023 GRANT lasts exactly 1 cycle, → WAIT_DONE.
  - tx_start=1; tx_sel, tx_len and tx_dst_mac are registered and held stable until the next GRANT.
  - For a UDP grant, udp_ack=1 in the same cycle.
REQ-024 Latency SHALL be 1 cycle: a request visible in IDLE at cycle N gives tx_start at cycle N+1.
REQ-025 WAIT_DONE SHALL count cycles.
  - tx_done → IFG.
  - Count reaching TIMEOUT_CYCLES → tx_timeout pulse, → IFG.
REQ-026 IFG SHALL last exactly IFG_CYCLES cycles, → IDLE; tx_active=0 only in IDLE.
REQ-027 A single counter SHALL serve both WAIT_DONE and IFG, cleared on every state entry.
REQ-028 Arbitration with both ARP and UDP pending SHALL be:
  - ARP wins, unless the previous grant was ARP, in which case UDP wins.
  - The last-grant flag resets to UDP.
REQ-029 ARP latching:
  - arp_req sets arp_pending and captures arp_mac.
  - An ARP grant clears arp_pending.
  - arp_req while already pending overwrites the MAC (latest wins); there is no queue.
REQ-030 arp_req in the same cycle as an ARP grant SHALL leave arp_pending=1 with the new MAC.
REQ-031 A UDP request with udp_len=0 or udp_len>1472, seen in IDLE, SHALL:
  - produce udp_ack and udp_len_err in the next cycle;
  - produce no tx_start and stay in IDLE.
REQ-032 tx_done outside WAIT_DONE SHALL be ignored.
REQ-033 arp_req SHALL be accepted in every state.
REQ-034 udp_req SHALL be sampled only in IDLE.

Reset
REQ-035 On gmii_rstn=0 the block SHALL enter IDLE asynchronously with all outputs at reset value:
  - udp_ack=0, udp_len_err=0, arp_pending=0, tx_start=0, tx_sel=0, tx_len=0, tx_dst_mac=0, tx_active=0, tx_timeout=0;
  - counter and last-grant flag cleared.
REQ-036 Reset asserted mid-frame SHALL drop any pending ARP and UDP request without generating an ack.
REQ-037 Reset deassertion SHALL be synchronous to gmii_tx_clk; the first possible grant is 1 cycle after release.

Structure
REQ-038 Package eth_pkg SHALL hold:
  - the state enum;
  - constants ARP_PAYLOAD_LEN=28, UDP_MAX_LEN=1472, TX_SEL_UDP=0, TX_SEL_ARP=1.
REQ-039 The block SHALL have no sub-module; the FSM, counter, ARP latch and arbiter live in eth_tx_arb (about 150–250 lines).

Verification
REQ-040 The bench SHALL cover the following directed scenarios:
  - Single UDP: udp_req with len=1024 → tx_start and udp_ack 1 cycle later, tx_sel=0, tx_len=1024; tx_done → tx_active falls exactly 12 cycles later.
  - Contention: arp_req and udp_req in the same IDLE cycle → ARP frame first (tx_len=28, tx_dst_mac=arp_mac), then UDP; the next concurrent pair after the UDP frame again grants ARP first.
  - ARP overwrite: two arp_req (MAC 112233445566, then AABBCCDDEEFF) during a UDP frame → exactly one ARP frame, with dst AABBCCDDEEFF.
  - Bad length: udp_req with len=0, and separately len=1500 → udp_ack and udp_len_err pulses, no tx_start.
  - Timeout: no tx_done after tx_start → tx_timeout at cycle 4096, then 12 IFG cycles, then IDLE.
  - Reset mid-frame: gmii_rstn low in WAIT_DONE with an ARP pending → all outputs 0 immediately; no frame after release.

Source files
------------

// File: rtl/eth_pkg.sv
// -----------------------------------------------------------------------------
// eth_pkg
// Shared definitions for the Ethernet transmit arbiter: the arbiter FSM state
// type, frame-type encodings, fixed payload lengths and a UDP length check.
// -----------------------------------------------------------------------------
package eth_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GRANT     = 2'd1,
        WAIT_DONE = 2'd2,
        IFG       = 2'd3
    } arb_state_t;

    localparam logic [10:0] ARP_PAYLOAD_LEN = 11'd28;
    localparam logic [10:0] UDP_MAX_LEN     = 11'd1472;

    localparam logic TX_SEL_UDP = 1'b0;
    localparam logic TX_SEL_ARP = 1'b1;

    // A UDP payload must carry at least one byte and fit one untagged frame.
    function automatic logic udp_len_ok(input logic [10:0] len);
        return (len != 11'd0) && (len <= UDP_MAX_LEN);
    endfunction

endpackage

// File: rtl/eth_tx_arb.sv
// -----------------------------------------------------------------------------
// eth_tx_arb
// Arbitrates between ARP replies and UDP frames for a single frame builder.
// It latches ARP requests, checks UDP lengths, grants one frame at a time,
// waits for the builder to finish or time out, and then enforces the
// inter-frame gap.
//
// Ports
//   gmii_tx_clk  in   clock, 125 MHz
//   gmii_rstn    in   asynchronous active-low reset
//   arp_req      in   one-cycle pulse requesting an ARP reply
//   arp_mac      in   [47:0] requester MAC, captured with arp_req
//   udp_req      in   level request, held until udp_ack
//   udp_len      in   [10:0] UDP payload length, valid range 1..1472
//   udp_mac      in   [47:0] UDP destination MAC, captured at grant
//   tx_done      in   pulse from the frame builder after its last FCS byte
//   udp_ack      out  pulse: UDP request consumed (granted or rejected)
//   udp_len_err  out  pulse: UDP request rejected for bad length
//   arp_pending  out  an ARP reply is latched and not yet granted
//   tx_start     out  pulse starting the frame builder
//   tx_sel       out  frame type, 0 = UDP, 1 = ARP
//   tx_len       out  [10:0] payload length of the granted frame
//   tx_dst_mac   out  [47:0] destination MAC of the granted frame
//   tx_active    out  high from tx_start until the inter-frame gap ends
//   tx_timeout   out  pulse when a frame is abandoned for lack of tx_done
// -----------------------------------------------------------------------------
module eth_tx_arb
    import eth_pkg::*;
#(
    parameter int IFG_CYCLES     = 12,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        gmii_tx_clk,
    input  logic        gmii_rstn,
    input  logic        arp_req,
    input  logic [47:0] arp_mac,
    input  logic        udp_req,
    input  logic [10:0] udp_len,
    input  logic [47:0] udp_mac,
    input  logic        tx_done,
    output logic        udp_ack,
    output logic        udp_len_err,
    output logic        arp_pending,
    output logic        tx_start,
    output logic        tx_sel,
    output logic [10:0] tx_len,
    output logic [47:0] tx_dst_mac,
    output logic        tx_active,
    output logic        tx_timeout
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] IFG_LAST     = CNT_W'(IFG_CYCLES - 1);
    // The tx_start cycle is cycle 0 and WAIT_DONE starts with the counter at
    // 0 one cycle later, so the abandon decision is taken two counts early.
    // That makes the registered tx_timeout appear TIMEOUT_CYCLES after tx_start.
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

    arb_state_t       state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             last_arp_reg;
    logic             arp_pending_reg;
    logic [47:0]      arp_mac_reg;
    logic             udp_ack_reg;
    logic             udp_len_err_reg;
    logic             tx_start_reg;
    logic             tx_sel_reg;
    logic [10:0]      tx_len_reg;
    logic [47:0]      tx_dst_mac_reg;
    logic             tx_active_reg;
    logic             tx_timeout_reg;

    // The requester sees udp_ack one cycle late and still holds udp_req.
    // Ignoring udp_req during the ack cycle prevents a second ack.
    logic        udp_seen;
    logic        udp_ok;
    logic        udp_bad;
    logic        arp_any;
    logic        in_idle;
    logic        grant_arp;
    logic        grant_udp;
    logic [47:0] grant_mac;

    assign udp_seen  = udp_req & ~udp_ack_reg;
    assign udp_ok    = udp_seen & udp_len_ok(udp_len);
    assign udp_bad   = udp_seen & ~udp_len_ok(udp_len);
    // A fresh arp_req counts as pending in the same IDLE cycle.
    // This gives single-cycle grant latency for ARP as well as for UDP.
    assign arp_any   = arp_pending_reg | arp_req;
    assign in_idle   = (state_reg == IDLE);
    // ARP wins contention unless it also won the previous grant.
    assign grant_arp = in_idle & arp_any & ~(udp_ok & last_arp_reg);
    assign grant_udp = in_idle & udp_ok & ~grant_arp;
    // A latched reply is served before a same-cycle request.
    // The same-cycle request then becomes the new latched reply.
    assign grant_mac = arp_pending_reg ? arp_mac_reg : arp_mac;

    always_ff @(posedge gmii_tx_clk or negedge gmii_rstn) begin
        if (!gmii_rstn) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            last_arp_reg    <= TX_SEL_UDP;
            arp_pending_reg <= 1'b0;
            arp_mac_reg     <= '0;
            udp_ack_reg     <= 1'b0;
            udp_len_err_reg <= 1'b0;
            tx_start_reg    <= 1'b0;
            tx_sel_reg      <= TX_SEL_UDP;
            tx_len_reg      <= '0;
            tx_dst_mac_reg  <= '0;
            tx_active_reg   <= 1'b0;
            tx_timeout_reg  <= 1'b0;
        end else begin
            udp_ack_reg     <= 1'b0;
            udp_len_err_reg <= 1'b0;
            tx_start_reg    <= 1'b0;
            tx_timeout_reg  <= 1'b0;

            // ARP latch. A request consumed directly by this cycle's grant
            // is not latched. Any other request overwrites the latch.
            if (arp_req && !(grant_arp && !arp_pending_reg)) begin
                arp_pending_reg <= 1'b1;
                arp_mac_reg     <= arp_mac;
            end else if (grant_arp) begin
                arp_pending_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (udp_bad) begin
                        udp_ack_reg     <= 1'b1;
                        udp_len_err_reg <= 1'b1;
                    end
                    if (grant_arp || grant_udp) begin
                        state_reg      <= GRANT;
                        cnt_reg        <= '0;
                        tx_start_reg   <= 1'b1;
                        tx_active_reg  <= 1'b1;
                        last_arp_reg   <= grant_arp;
                        tx_sel_reg     <= grant_arp ? TX_SEL_ARP : TX_SEL_UDP;
                        tx_len_reg     <= grant_arp ? ARP_PAYLOAD_LEN : udp_len;
                        tx_dst_mac_reg <= grant_arp ? grant_mac : udp_mac;
                        if (grant_udp) begin
                            udp_ack_reg <= 1'b1;
                        end
                    end
                end
                GRANT: begin
                    state_reg <= WAIT_DONE;
                    cnt_reg   <= '0;
                end
                WAIT_DONE: begin
                    if (tx_done) begin
                        state_reg <= IFG;
                        cnt_reg   <= '0;
                    end else if (cnt_reg == TIMEOUT_LAST) begin
                        tx_timeout_reg <= 1'b1;
                        state_reg      <= IFG;
                        cnt_reg        <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                IFG: begin
                    if (cnt_reg == IFG_LAST) begin
                        state_reg     <= IDLE;
                        cnt_reg       <= '0;
                        tx_active_reg <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    assign udp_ack     = udp_ack_reg;
    assign udp_len_err = udp_len_err_reg;
    assign arp_pending = arp_pending_reg;
    assign tx_start    = tx_start_reg;
    assign tx_sel      = tx_sel_reg;
    assign tx_len      = tx_len_reg;
    assign tx_dst_mac  = tx_dst_mac_reg;
    assign tx_active   = tx_active_reg;
    assign tx_timeout  = tx_timeout_reg;

endmodule

// File: tb/tb_eth_tx_arb.sv
// -----------------------------------------------------------------------------
// tb_eth_tx_arb
// Directed bench for eth_tx_arb. Inputs change 1 ns after the rising edge, and
// outputs are checked at that same point, one step after the edge.
// -----------------------------------------------------------------------------
module tb_eth_tx_arb;

    logic        gmii_tx_clk;
    logic        gmii_rstn;
    logic        arp_req;
    logic [47:0] arp_mac;
    logic        udp_req;
    logic [10:0] udp_len;
    logic [47:0] udp_mac;
    logic        tx_done;
    logic        udp_ack;
    logic        udp_len_err;
    logic        arp_pending;
    logic        tx_start;
    logic        tx_sel;
    logic [10:0] tx_len;
    logic [47:0] tx_dst_mac;
    logic        tx_active;
    logic        tx_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    eth_tx_arb dut (
        .gmii_tx_clk (gmii_tx_clk),
        .gmii_rstn   (gmii_rstn),
        .arp_req     (arp_req),
        .arp_mac     (arp_mac),
        .udp_req     (udp_req),
        .udp_len     (udp_len),
        .udp_mac     (udp_mac),
        .tx_done     (tx_done),
        .udp_ack     (udp_ack),
        .udp_len_err (udp_len_err),
        .arp_pending (arp_pending),
        .tx_start    (tx_start),
        .tx_sel      (tx_sel),
        .tx_len      (tx_len),
        .tx_dst_mac  (tx_dst_mac),
        .tx_active   (tx_active),
        .tx_timeout  (tx_timeout)
    );

    initial gmii_tx_clk = 1'b0;
    always #4 gmii_tx_clk = ~gmii_tx_clk;

    task automatic step();
        @(posedge gmii_tx_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called in a GRANT cycle. The builder reports tx_done in the first
    // WAIT_DONE cycle, and the task returns in the first IDLE cycle.
    task automatic finish_frame();
        step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        repeat (12) step();
    endtask

    initial begin
        gmii_rstn = 1'b0;
        arp_req   = 1'b0;
        arp_mac   = '0;
        udp_req   = 1'b0;
        udp_len   = '0;
        udp_mac   = '0;
        tx_done   = 1'b0;

        // ---------------- reset state ----------------
        #21;
        check("rst_tx_start",    tx_start,    0);
        check("rst_tx_active",   tx_active,   0);
        check("rst_arp_pending", arp_pending, 0);
        check("rst_tx_len",      tx_len,      0);
        check("rst_tx_dst_mac",  tx_dst_mac,  0);
        check("rst_udp_ack",     udp_ack,     0);
        step();
        gmii_rstn = 1'b1;
        step();

        // ---------------- single UDP ----------------
        udp_req = 1'b1; udp_len = 11'd1024; udp_mac = 48'h0A0B0C0D0E0F;
        step();
        check("udp1_tx_start", tx_start,   1);
        check("udp1_ack",      udp_ack,    1);
        check("udp1_sel",      tx_sel,     0);
        check("udp1_len",      tx_len,     1024);
        check("udp1_mac",      tx_dst_mac, 48'h0A0B0C0D0E0F);
        check("udp1_active",   tx_active,  1);
        udp_req = 1'b0;
        step();
        check("udp1_start_low", tx_start, 0);
        check("udp1_ack_low",   udp_ack,  0);
        step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        repeat (11) step();
        check("udp1_ifg_last_active", tx_active, 1);
        step();
        check("udp1_idle_inactive", tx_active, 0);

        // ---------------- contention ----------------
        arp_req = 1'b1; arp_mac = 48'h0000000000A1;
        udp_req = 1'b1; udp_len = 11'd100; udp_mac = 48'h0000000000B1;
        step();
        arp_req = 1'b0;
        check("cont1_start",   tx_start,    1);
        check("cont1_sel_arp", tx_sel,      1);
        check("cont1_len",     tx_len,      28);
        check("cont1_mac",     tx_dst_mac,  48'h0000000000A1);
        check("cont1_no_ack",  udp_ack,     0);
        check("cont1_pending", arp_pending, 0);
        finish_frame();
        step();
        check("cont1_udp_sel", tx_sel,     0);
        check("cont1_udp_len", tx_len,     100);
        check("cont1_udp_mac", tx_dst_mac, 48'h0000000000B1);
        check("cont1_udp_ack", udp_ack,    1);
        udp_req = 1'b0;
        finish_frame();
        arp_req = 1'b1; arp_mac = 48'h0000000000A2;
        udp_req = 1'b1; udp_len = 11'd200; udp_mac = 48'h0000000000B2;
        step();
        arp_req = 1'b0;
        check("cont2_sel_arp", tx_sel,     1);
        check("cont2_mac",     tx_dst_mac, 48'h0000000000A2);
        finish_frame();
        step();
        check("cont2_udp_sel", tx_sel, 0);
        check("cont2_udp_len", tx_len, 200);
        udp_req = 1'b0;
        finish_frame();

        // ---------------- ARP overwrite ----------------
        udp_req = 1'b1; udp_len = 11'd64; udp_mac = 48'h0000000000B3;
        step();
        check("ovw_udp_start", tx_start, 1);
        udp_req = 1'b0;
        step();
        arp_req = 1'b1; arp_mac = 48'h112233445566;
        step();
        arp_req = 1'b0;
        check("ovw_pending1", arp_pending, 1);
        step();
        arp_req = 1'b1; arp_mac = 48'hAABBCCDDEEFF;
        step();
        arp_req = 1'b0;
        check("ovw_pending2", arp_pending, 1);
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        repeat (12) step();
        check("ovw_idle", tx_active, 0);
        step();
        check("ovw_arp_start", tx_start,    1);
        check("ovw_arp_sel",   tx_sel,      1);
        check("ovw_arp_mac",   tx_dst_mac,  48'hAABBCCDDEEFF);
        check("ovw_cleared",   arp_pending, 0);
        finish_frame();
        step();
        check("ovw_single_frame", tx_start, 0);
        check("ovw_stay_idle",    tx_active, 0);

        // ---------------- bad length ----------------
        udp_req = 1'b1; udp_len = 11'd0;
        step();
        udp_req = 1'b0;
        check("bad0_ack",      udp_ack,     1);
        check("bad0_err",      udp_len_err, 1);
        check("bad0_no_start", tx_start,    0);
        check("bad0_idle",     tx_active,   0);
        step();
        check("bad0_ack_low",  udp_ack,     0);
        udp_req = 1'b1; udp_len = 11'd1500;
        step();
        udp_req = 1'b0;
        check("bad1500_ack",      udp_ack,     1);
        check("bad1500_err",      udp_len_err, 1);
        check("bad1500_no_start", tx_start,    0);
        step();
        check("bad1500_err_low",  udp_len_err, 0);
        check("bad1500_still_idle", tx_active, 0);
        udp_req = 1'b1; udp_len = 11'd1472; udp_mac = 48'h0000000000B4;
        step();
        udp_req = 1'b0;
        check("max_len_start", tx_start,    1);
        check("max_len_len",   tx_len,      1472);
        check("max_len_noerr", udp_len_err, 0);
        finish_frame();

        // ---------------- timeout ----------------
        udp_req = 1'b1; udp_len = 11'd10; udp_mac = 48'h0000000000B5;
        step();
        udp_req = 1'b0;
        check("to_start", tx_start, 1);
        repeat (4095) step();
        check("to_not_yet",  tx_timeout, 0);
        check("to_active",   tx_active,  1);
        step();
        check("to_pulse",    tx_timeout, 1);
        step();
        check("to_pulse_end", tx_timeout, 0);
        repeat (10) step();
        check("to_ifg_last", tx_active, 1);
        step();
        check("to_idle",     tx_active, 0);

        // ---------------- reset mid-frame ----------------
        udp_req = 1'b1; udp_len = 11'd50; udp_mac = 48'h0000000000B6;
        step();
        udp_req = 1'b0;
        step();
        arp_req = 1'b1; arp_mac = 48'h0000000000C1;
        step();
        arp_req = 1'b0;
        check("rm_pending",  arp_pending, 1);
        check("rm_active",   tx_active,   1);
        gmii_rstn = 1'b0;
        #1;
        check("rm_active0",  tx_active,   0);
        check("rm_pending0", arp_pending, 0);
        check("rm_len0",     tx_len,      0);
        check("rm_mac0",     tx_dst_mac,  0);
        check("rm_start0",   tx_start,    0);
        check("rm_ack0",     udp_ack,     0);
        step();
        step();
        gmii_rstn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("rm_no_frame", {tx_start, tx_active, udp_ack}, 0);
        end
        udp_req = 1'b1; udp_len = 11'd33; udp_mac = 48'h0000000000B7;
        step();
        udp_req = 1'b0;
        check("rm_first_grant", tx_start, 1);
        check("rm_first_len",   tx_len,   33);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
